// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// Holds the FSM state encoding and the select-to-grant decode.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_REQ-1:0] onehot;
    onehot = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the arbiter.
// Handshake: req[i] is held by requester i until it is done; ownership starts on the
// first clock edge after which gnt[i]=1 and lasts until req[i] is dropped or preempted.
interface mux4_rr_arbiter_if;
  import mux4_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin search: first set req bit starting at ptr+1, wrapping,
// with ptr itself checked last.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with bounded hold time.
// All outputs are registered; the FSM state and hold counter are exported for checking.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus,
  output state_t            state,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  // With unlimited hold the counter still saturates rather than wrapping.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_LIM;
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             others_waiting;

  // last always equals the current owner while granted, so one picker serves both cases.
  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign others_waiting = |(bus.req & ~gnt_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          last_d  = pick_idx;
          sel_d   = pick_idx;
          gnt_d   = sel_onehot(pick_idx);
          hold_d  = HOLD_ONE;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          if (pick_found) begin
            last_d = pick_idx;
            sel_d  = pick_idx;
            gnt_d  = sel_onehot(pick_idx);
            hold_d = HOLD_ONE;
          end else begin
            // sel is left alone so the mux output does not glitch while idle.
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (PREEMPT_EN && hold_q == HOLD_LIM && others_waiting) begin
          last_d = pick_idx;
          sel_d  = pick_idx;
          gnt_d  = sel_onehot(pick_idx);
          hold_d = HOLD_ONE;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SEL_W'(N_REQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign state    = state_q;
  assign hold_cnt = hold_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_busy_eq     : assert property (@(posedge clk) disable iff (rst) busy_q == (|gnt_q));
  a_gnt_sel     : assert property (@(posedge clk) disable iff (rst)
                                   (gnt_q != '0) |-> (gnt_q == sel_onehot(sel_q)));

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 multiplexer between four requesters.
- Converts a 4-bit request vector into a registered one-hot grant and a 2-bit select code.
- The select code drives the mux select inputs directly, and the mux output goes to a single downstream consumer.
- A grant is held while the owner keeps its request asserted. After MAX_HOLD cycles the owner is preempted, but only if another requester is waiting.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before preemption when others are waiting; 0 = unlimited hold.
- HOLD_W, 4, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request vector; bit i = requester i (i0..i3 mux input)
- gnt  output 4  registered one-hot grant; all-zero when idle
- sel  output 2  registered mux select code = index of granted requester
- busy output 1  registered; 1 while any grant is active (equals |gnt)

Behaviour:
- Reset (async, immediate, also mid-grant):
  - gnt=4'b0000, sel=2'b00, busy=0, state=IDLE, hold_cnt=0.
  - last=3, so requester 0 has top priority on the first grant.
- States: IDLE, GRANT. All outputs are registered; no combinational path from req to any output.
- Round-robin pick: search order is last+1, last+2, last+3, last (mod 4); the first set req bit wins. On every new grant, last <= winner.
- IDLE:
  - If req != 0 at an edge: gnt/sel/busy show the winner after that edge (1-cycle latency), state -> GRANT, hold_cnt <= 1.
  - Otherwise stay in IDLE. sel keeps its previous value so the mux output is stable. gnt=0.
- GRANT, owner = sel. Evaluated at each edge in this priority order:
  1. Release: req[owner]==0.
     - If other requests are pending: grant the next one in RR order from the owner at the same edge (back-to-back, no idle bubble), hold_cnt <= 1.
     - If none are pending: state -> IDLE, gnt <= 0, busy <= 0, sel unchanged.
  2. Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD, req[owner]==1 and some other req bit set.
     - Grant the next requester in RR order from the owner, hold_cnt <= 1.
     - The preempted owner re-competes normally; its request stays asserted.
  3. Otherwise: keep the grant. hold_cnt <= hold_cnt+1, saturating at MAX_HOLD. A lone owner is never preempted.
- Grant switching:
  - The switch happens on one edge: gnt changes one-hot to one-hot, never two bits set, never X.
  - sel changes on the same edge as gnt.
- Simultaneous events:
  - Release plus new requests at one edge: resolved by RR from the old owner.
  - Requests that rise and fall entirely between edges are not seen.
- Hold counter width: HOLD_W bits, no wrap (saturates).
- Invariants checked by the bench:
  - gnt is always onehot0.
  - busy == |gnt.
  - gnt != 0 implies gnt == (1 << sel).

Decomposition:
- Shared package mux4_arb_pkg:
  - N_REQ=4, SEL_W=2.
  - State encoding IDLE=1'b0, GRANT=1'b1.
  - Function/constant for one-hot decode of sel.
- One combinational sub-module rr_pick4:
  - Inputs: req[3:0], ptr[1:0]. Outputs: idx[1:0], found.
  - Searches from ptr+1 with wrap. Used for both the IDLE grant and the release/preempt re-grant.
- Top module contains: the FSM, the hold counter, and the last/sel/gnt registers.

Test Plan:
- Reset: assert rst mid-grant with req=4'b1111 -> gnt=0, sel=0, busy=0 immediately, without waiting for a clock; after release the first grant goes to requester 0.
- Single request: req=4'b0100 from IDLE -> one edge later gnt=4'b0100, sel=2; drop req -> gnt=0 after the next edge, sel stays 2.
- Rotation: req=4'b1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 with each owner holding exactly 8 cycles; no idle cycle between owners.
- Back-to-back release: owner 1 drops req on the same edge that req3 rises, with req0 also pending -> next grant is 3 (RR from 1 skips 2), not 0.
- Lone owner: req=4'b0001 held for 50 cycles, MAX_HOLD=8 -> gnt stays 4'b0001 throughout, hold_cnt saturates at 8; assert req[2] -> switch to 2 on the next edge.
- Unlimited hold: MAX_HOLD=0, req=4'b0011 -> requester 0 keeps the grant until it drops req, then 1 is granted on the same edge.
